// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word field positions, mode/op-type encodings and
// the fetch FSM state type. Optional macro: FETCH_ILLEGAL_TRAP_EN adds the StTrap state.
package cpu_pkg;

  // Instruction word field positions
  localparam int unsigned BC_MSB   = 15;
  localparam int unsigned BC_LSB   = 14;
  localparam int unsigned MODE_MSB = 13;
  localparam int unsigned MODE_LSB = 12;
  localparam int unsigned OT_MSB   = 11;
  localparam int unsigned OT_LSB   = 10;
  localparam int unsigned OP1_MSB  = 9;
  localparam int unsigned OP1_LSB  = 7;
  localparam int unsigned OP2_MSB  = 6;
  localparam int unsigned OP2_LSB  = 4;
  localparam int unsigned OPC_MSB  = 3;
  localparam int unsigned OPC_LSB  = 0;

  // Addressing modes
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b01;
  localparam logic [1:0] MODE_DIR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // Op type reserved for illegal instructions
  localparam logic [1:0] OT_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    StF1,
    StW1,
    StW2,
`ifdef FETCH_ILLEGAL_TRAP_EN
    StTrap,
`endif
    StHold
  } fetch_state_e;

endpackage

// File: rtl/ins_len_decode.sv
// Combinational instruction length / legality decode of a fetched instruction word.
module ins_len_decode
  import cpu_pkg::*;
(
  input  logic [15:0] word_i,
  output logic        two_word_o,
  output logic        illegal_o
);

  logic [1:0] mode;
  logic [1:0] op_type;

  assign mode    = word_i[MODE_MSB:MODE_LSB];
  assign op_type = word_i[OT_MSB:OT_LSB];

  // Immediate and direct modes carry an extension word
  assign two_word_o = (mode == MODE_IMM) || (mode == MODE_DIR);
  assign illegal_o  = (op_type == OT_ILLEGAL) || (mode == MODE_RSV);

  // Remaining fields are decoded downstream
  logic unused_word;
  assign unused_word = ^{word_i[BC_MSB:BC_LSB], word_i[OP1_MSB:OPC_LSB]};

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC, reads the synchronous program ROM, assembles one- or
// two-word instructions and presents them to the decoder over valid/ready.
// Optional macro: FETCH_ILLEGAL_TRAP_EN (trap on illegal words, raises fetch_illegal).
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_ins,
  output logic [DATA_W-1:0] fetch_ext,
  output logic              fetch_two_word,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_illegal
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] ins_d, ins_q;
  logic [DATA_W-1:0] ext_d, ext_q;
  logic              two_d, two_q;
  logic [ADDR_W-1:0] fpc_d, fpc_q;
  logic              ill_d, ill_q;
  logic              dec_two_word;
  logic              dec_illegal;

  ins_len_decode u_len_decode (
    .word_i     (rom_data),
    .two_word_o (dec_two_word),
    .illegal_o  (dec_illegal)
  );

  // Next-state logic; a redirect overrides everything and drops any partial instruction
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ins_d   = ins_q;
    ext_d   = ext_q;
    two_d   = two_q;
    fpc_d   = fpc_q;
    ill_d   = ill_q;
    if (pc_load) begin
      state_d = StF1;
      pc_d    = pc_load_addr;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else begin
      unique case (state_q)
        StF1: begin
          if (en) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StW1;
          end
        end
        StW1: begin
          // The PC already points past the word now on rom_data
          ins_d = rom_data;
          fpc_d = pc_q - ADDR_W'(1);
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (dec_illegal) begin
            ill_d   = 1'b1;
            state_d = StTrap;
          end else
`endif
          if (dec_two_word) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StW2;
          end else begin
            ext_d   = '0;
            two_d   = 1'b0;
            valid_d = 1'b1;
            state_d = StHold;
          end
        end
        StW2: begin
          ext_d   = rom_data;
          two_d   = 1'b1;
          valid_d = 1'b1;
          state_d = StHold;
        end
        StHold: begin
          if (fetch_ready) begin
            valid_d = 1'b0;
            state_d = StF1;
          end
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        StTrap: begin
          // PC frozen; only a redirect or reset leaves this state
          state_d = StTrap;
        end
`endif
        default: state_d = StF1;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StF1;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ins_q   <= '0;
      ext_q   <= '0;
      two_q   <= 1'b0;
      fpc_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ins_q   <= ins_d;
      ext_q   <= ext_d;
      two_q   <= two_d;
      fpc_q   <= fpc_d;
      ill_q   <= ill_d;
    end
  end

  assign rom_addr       = pc_q;
  assign fetch_valid    = valid_q;
  assign fetch_ins      = ins_q;
  assign fetch_ext      = ext_q;
  assign fetch_two_word = two_q;
  assign fetch_pc       = fpc_q;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign fetch_illegal = ill_q;
`else
  assign fetch_illegal = 1'b0;
  logic unused_trap;
  assign unused_trap = ^{dec_illegal, ill_q};
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a synchronous ROM model and an expected-instruction queue.
module tb_ins_fetch;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [15:0] fetch_ins;
  logic [15:0] fetch_ext;
  logic        fetch_two_word;
  logic [15:0] fetch_pc;
  logic        fetch_illegal;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] ext;
    logic        two;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] rom_mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          n;

  ins_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pc_load        (pc_load),
    .pc_load_addr   (pc_load_addr),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_ins      (fetch_ins),
    .fetch_ext      (fetch_ext),
    .fetch_two_word (fetch_two_word),
    .fetch_pc       (fetch_pc),
    .fetch_illegal  (fetch_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for rom_addr appears after the next rising edge
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] ins, input logic [15:0] ext, input logic two,
                      input logic [15:0] pc);
    exp_t e;
    e.ins = ins;
    e.ext = ext;
    e.two = two;
    e.pc  = pc;
    sb_q.push_back(e);
  endtask

  // Count falling edges until fetch_valid rises, bounded by budget
  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (fetch_valid !== 1'b1 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk("valid_timeout", {31'd0, fetch_valid}, 32'd1);
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ins", {16'd0, fetch_ins}, {16'd0, e.ins});
      chk("ext", {16'd0, fetch_ext}, {16'd0, e.ext});
      chk("two_word", {31'd0, fetch_two_word}, {31'd0, e.two});
      chk("pc", {16'd0, fetch_pc}, {16'd0, e.pc});
      chk("illegal", {31'd0, fetch_illegal}, 32'd0);
    end
  endtask

  task automatic handshake();
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    fetch_ready  = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    for (int i = 0; i < 65536; i++) rom_mem[i] = '0;
    rom_mem[0]     = 16'h0013;
    rom_mem[1]     = 16'h1123;
    rom_mem[2]     = 16'h00AB;
    rom_mem[3]     = 16'h2010;
    rom_mem[4]     = 16'hBEEF;
    rom_mem[16'h40] = 16'h0007;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_ins", {16'd0, fetch_ins}, 32'd0);
    chk("rst_ext", {16'd0, fetch_ext}, 32'd0);
    chk("rst_two", {31'd0, fetch_two_word}, 32'd0);
    chk("rst_pc", {16'd0, fetch_pc}, 32'd0);
    chk("rst_illegal", {31'd0, fetch_illegal}, 32'd0);
    chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);

    // One-word instruction, latency 2
    rst_n = 1'b1;
    en    = 1'b1;
    push(16'h0013, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    chk("w1_valid", {31'd0, fetch_valid}, 32'd0);
    chk("w1_rom_addr", {16'd0, rom_addr}, 32'd1);
    @(negedge clk);
    chk("lat1_valid", {31'd0, fetch_valid}, 32'd1);
    pop_check();

    // Two-word instruction, latency 3 from F1
    push(16'h1123, 16'h00AB, 1'b1, 16'h0001);
    handshake();
    chk("hs_valid_drop", {31'd0, fetch_valid}, 32'd0);
    wait_valid(10, n);
    chk("lat2_cycles", n, 32'd3);
    pop_check();
    chk("next_rom_addr", {16'd0, rom_addr}, 32'd3);

    // Backpressure: outputs and address stable while not ready
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, fetch_valid}, 32'd1);
      chk("hold_ins", {16'd0, fetch_ins}, 32'h1123);
      chk("hold_ext", {16'd0, fetch_ext}, 32'h00AB);
      chk("hold_rom_addr", {16'd0, rom_addr}, 32'd3);
    end
    handshake();
    chk("hold_release", {31'd0, fetch_valid}, 32'd0);

    // Redirect during W2 discards the extension
    @(negedge clk);
    @(negedge clk);
    pc_load      = 1'b1;
    pc_load_addr = 16'h0040;
    @(negedge clk);
    pc_load = 1'b0;
    chk("redir_valid", {31'd0, fetch_valid}, 32'd0);
    chk("redir_rom_addr", {16'd0, rom_addr}, 32'h40);
    push(16'h0007, 16'h0000, 1'b0, 16'h0040);
    wait_valid(10, n);
    chk("redir_cycles", n, 32'd2);
    pop_check();

    // Redirect together with handshake; two-word wrap at FFFF
    rom_mem[16'hFFFF] = 16'h1100;
    rom_mem[0]        = 16'h5555;
    push(16'h1100, 16'h5555, 1'b1, 16'hFFFF);
    fetch_ready  = 1'b1;
    pc_load      = 1'b1;
    pc_load_addr = 16'hFFFF;
    @(negedge clk);
    fetch_ready = 1'b0;
    pc_load     = 1'b0;
    chk("wrap_valid", {31'd0, fetch_valid}, 32'd0);
    chk("wrap_rom_addr", {16'd0, rom_addr}, 32'hFFFF);
    wait_valid(10, n);
    chk("wrap_cycles", n, 32'd3);
    pop_check();
    chk("wrap_next_addr", {16'd0, rom_addr}, 32'd1);
    push(16'h1123, 16'h00AB, 1'b1, 16'h0001);
    handshake();
    wait_valid(10, n);
    pop_check();

    // en low holds in F1
    en = 1'b0;
    handshake();
    repeat (4) @(negedge clk);
    chk("en_valid", {31'd0, fetch_valid}, 32'd0);
    chk("en_rom_addr", {16'd0, rom_addr}, 32'd3);
    en = 1'b1;

    // Asynchronous reset mid-instruction
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("arst_rom_addr", {16'd0, rom_addr}, 32'd0);
    chk("arst_ins", {16'd0, fetch_ins}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h5555, 16'h1123, 1'b1, 16'h0000);
    wait_valid(10, n);
    chk("post_rst_cycles", n, 32'd3);
    pop_check();

    // Illegal op type word at 0x0005
    rom_mem[5] = 16'h0C00;
    rom_mem[6] = 16'h3000;
    fetch_ready  = 1'b1;
    pc_load      = 1'b1;
    pc_load_addr = 16'h0005;
    @(negedge clk);
    fetch_ready = 1'b0;
    pc_load     = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    repeat (6) @(negedge clk);
    chk("trap_illegal", {31'd0, fetch_illegal}, 32'd1);
    chk("trap_valid", {31'd0, fetch_valid}, 32'd0);
    chk("trap_pc", {16'd0, fetch_pc}, 32'd5);
    chk("trap_ins", {16'd0, fetch_ins}, 32'h0C00);
    chk("trap_rom_addr", {16'd0, rom_addr}, 32'd6);
    pc_load      = 1'b1;
    pc_load_addr = 16'h0040;
    @(negedge clk);
    pc_load = 1'b0;
    chk("trap_exit", {31'd0, fetch_illegal}, 32'd0);
    chk("trap_exit_addr", {16'd0, rom_addr}, 32'h40);
    push(16'h0007, 16'h0000, 1'b0, 16'h0040);
    wait_valid(10, n);
    chk("trap_exit_cycles", n, 32'd2);
    pop_check();
`else
    push(16'h0C00, 16'h0000, 1'b0, 16'h0005);
    wait_valid(10, n);
    chk("ot11_cycles", n, 32'd2);
    pop_check();
    push(16'h3000, 16'h0000, 1'b0, 16'h0006);
    handshake();
    wait_valid(10, n);
    chk("mode11_cycles", n, 32'd2);
    pop_check();
`endif

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
